// File: rtl/mc_pkg.sv
// Shared types and frame-layout helpers for the array arbiter.
// Frame layout, MSB first: {sof, eof, rw_flag, raddr, caddr, data}.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_XFER = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_XFER = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_REF     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_RD   = 2'd2,
    SEL_REF  = 2'd3
  } sel_e;

  // Field offsets are functions so that non-default widths stay consistent.
  function automatic int unsigned caddr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned raddr_lsb(input int unsigned dw, input int unsigned cw);
    return dw + cw;
  endfunction

  function automatic int unsigned rw_bit(input int unsigned dw, input int unsigned rw,
                                         input int unsigned cw);
    return dw + rw + cw;
  endfunction

  function automatic int unsigned eof_bit(input int unsigned dw, input int unsigned rw,
                                          input int unsigned cw);
    return dw + rw + cw + 1;
  endfunction

  function automatic int unsigned sof_bit(input int unsigned dw, input int unsigned rw,
                                          input int unsigned cw);
    return dw + rw + cw + 2;
  endfunction

endpackage

// File: rtl/mc_array_arbiter_if.sv
// Bus bundle between frame builders, array controllers, refresh engine and the arbiter.
interface mc_array_arbiter_if #(
  parameter int unsigned FRAME_WIDTH = 87,
  parameter int unsigned REFI_WIDTH  = 16
);
  logic [REFI_WIDTH-1:0]  mc_trefi_cfg;
  logic [FRAME_WIDTH-1:0] wr_frame_data;
  logic                   wr_frame_valid;
  logic                   wr_frame_ready;
  logic [FRAME_WIDTH-1:0] rd_frame_data;
  logic                   rd_frame_valid;
  logic                   rd_frame_ready;
  logic [FRAME_WIDTH-1:0] axi_wframe_data;
  logic                   axi_wframe_valid;
  logic                   axi_wframe_ready;
  logic                   write_finish;
  logic [FRAME_WIDTH-1:0] axi_rframe_data;
  logic                   axi_rframe_valid;
  logic                   axi_rframe_ready;
  logic                   read_finish;
  logic                   refresh_req;
  logic                   refresh_finish;
  logic [1:0]             array_sel;
  logic                   frame_err;
  logic                   ref_miss;

  modport slave (
    input  mc_trefi_cfg,
    input  wr_frame_data, wr_frame_valid, output wr_frame_ready,
    input  rd_frame_data, rd_frame_valid, output rd_frame_ready,
    output axi_wframe_data, axi_wframe_valid, input axi_wframe_ready, input write_finish,
    output axi_rframe_data, axi_rframe_valid, input axi_rframe_ready, input read_finish,
    output refresh_req, input refresh_finish,
    output array_sel, frame_err, ref_miss
  );

  modport master (
    output mc_trefi_cfg,
    output wr_frame_data, wr_frame_valid, input wr_frame_ready,
    output rd_frame_data, rd_frame_valid, input rd_frame_ready,
    input  axi_wframe_data, axi_wframe_valid, output axi_wframe_ready, output write_finish,
    input  axi_rframe_data, axi_rframe_valid, output axi_rframe_ready, output read_finish,
    input  refresh_req, output refresh_finish,
    input  array_sel, frame_err, ref_miss
  );
endinterface

// File: rtl/mc_refi_timer.sv
// Refresh interval timer: counts down from cfg-1, flags a pending refresh on expiry,
// and pulses ref_miss when it expires while a refresh is still pending.
module mc_refi_timer #(
  parameter int unsigned REFI_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REFI_WIDTH-1:0] trefi_cfg,
  input  logic                  clear_pending,
  output logic                  ref_pending,
  output logic                  ref_miss
);
  logic [REFI_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  miss_q, miss_d;
  logic                  expire;

  always_comb begin
    expire    = (trefi_cfg != '0) && (cnt_q == '0);
    cnt_d     = cnt_q - REFI_WIDTH'(1);
    pending_d = pending_q;
    if (trefi_cfg == '0) begin
      cnt_d = '0;
    end else if (expire) begin
      cnt_d = trefi_cfg - REFI_WIDTH'(1);
    end
    // A fresh expiry outranks the clear so a back-to-back interval is never lost.
    if (clear_pending) pending_d = 1'b0;
    if (expire)        pending_d = 1'b1;
    miss_d = expire && pending_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
    end
  end

  assign ref_pending = pending_q;
  assign ref_miss    = miss_q;
endmodule

// File: rtl/mc_array_arbiter.sv
// Grants the shared array to one write burst, read burst or refresh at a time,
// holding each grant until the owner reports finish.
module mc_array_arbiter
  import mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned RADDR_WIDTH = 14,
  parameter int unsigned CADDR_WIDTH = 6,
  parameter int unsigned REFI_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  mc_array_arbiter_if.slave bus
);
  localparam int unsigned FRAME_WIDTH = DATA_WIDTH + RADDR_WIDTH + CADDR_WIDTH + 3;
  localparam int unsigned SOF_POS = sof_bit(DATA_WIDTH, RADDR_WIDTH, CADDR_WIDTH);
  localparam int unsigned EOF_POS = eof_bit(DATA_WIDTH, RADDR_WIDTH, CADDR_WIDTH);

  state_e state_q, state_d;
  sel_e   sel_q, sel_d;
  logic   last_wr_q, last_wr_d;
  logic   frame_err_q, frame_err_d;

  logic [FRAME_WIDTH-1:0] wr_frame, rd_frame;
  logic wr_req, rd_req, wr_drop, rd_drop;
  logic wr_ready, rd_ready, axi_wvalid, axi_rvalid;
  logic ref_pending, clear_pending;

  assign wr_frame = bus.wr_frame_data;
  assign rd_frame = bus.rd_frame_data;
  assign wr_req   = bus.wr_frame_valid && wr_frame[SOF_POS];
  assign rd_req   = bus.rd_frame_valid && rd_frame[SOF_POS];

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    clear_pending = 1'b0;
    wr_drop       = 1'b0;
    rd_drop       = 1'b0;
    wr_ready      = 1'b0;
    rd_ready      = 1'b0;
    axi_wvalid    = 1'b0;
    axi_rvalid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A granted stream always carries sof, so it can never also be dropped.
        wr_drop  = bus.wr_frame_valid && !wr_frame[SOF_POS];
        rd_drop  = bus.rd_frame_valid && !rd_frame[SOF_POS];
        wr_ready = wr_drop;
        rd_ready = rd_drop;
        if (ref_pending) begin
          state_d       = ST_REF;
          clear_pending = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d = ST_WR_XFER;
        end else if (rd_req) begin
          state_d = ST_RD_XFER;
        end
      end
      ST_WR_XFER: begin
        axi_wvalid = bus.wr_frame_valid;
        wr_ready   = bus.axi_wframe_ready;
        if (bus.wr_frame_valid && bus.axi_wframe_ready && wr_frame[EOF_POS]) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (bus.write_finish) begin
          state_d   = ST_IDLE;
          last_wr_d = 1'b1;
        end
      end
      ST_RD_XFER: begin
        axi_rvalid = bus.rd_frame_valid;
        rd_ready   = bus.axi_rframe_ready;
        if (bus.rd_frame_valid && bus.axi_rframe_ready && rd_frame[EOF_POS]) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.read_finish) begin
          state_d   = ST_IDLE;
          last_wr_d = 1'b0;
        end
      end
      ST_REF: begin
        if (bus.refresh_finish) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_XFER, ST_WR_WAIT: sel_d = SEL_WR;
      ST_RD_XFER, ST_RD_WAIT: sel_d = SEL_RD;
      ST_REF:                 sel_d = SEL_REF;
      default:                sel_d = SEL_NONE;
    endcase
    frame_err_d = wr_drop || rd_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_NONE;
      last_wr_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_wr_q   <= last_wr_d;
      frame_err_q <= frame_err_d;
    end
  end

  mc_refi_timer #(.REFI_WIDTH(REFI_WIDTH)) u_refi_timer (
    .clk          (clk),
    .rst          (rst),
    .trefi_cfg    (bus.mc_trefi_cfg),
    .clear_pending(clear_pending),
    .ref_pending  (ref_pending),
    .ref_miss     (bus.ref_miss)
  );

  assign bus.axi_wframe_data  = wr_frame;
  assign bus.axi_rframe_data  = rd_frame;
  assign bus.axi_wframe_valid = axi_wvalid;
  assign bus.axi_rframe_valid = axi_rvalid;
  assign bus.wr_frame_ready   = wr_ready;
  assign bus.rd_frame_ready   = rd_ready;
  assign bus.refresh_req      = (state_q == ST_REF);
  assign bus.array_sel        = sel_q;
  assign bus.frame_err        = frame_err_q;
endmodule

// File: tb/tb_mc_array_arbiter.sv
// Scoreboard bench for mc_array_arbiter: directed bursts, round-robin, drop, refresh and reset.
module tb_mc_array_arbiter;
  localparam int unsigned FW = 87;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;
  int err_exp = 0;
  int miss_seen = 0;
  logic [FW-1:0] exp_w[$];
  logic [FW-1:0] exp_r[$];

  mc_array_arbiter_if #(.FRAME_WIDTH(FW), .REFI_WIDTH(16)) bus ();

  mc_array_arbiter #(
    .DATA_WIDTH (64),
    .RADDR_WIDTH(14),
    .CADDR_WIDTH(6),
    .REFI_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [FW-1:0] mk(input logic sof, input logic eof, input logic rw,
                                       input logic [63:0] d);
    logic [13:0] ra;
    logic [5:0]  ca;
    ra = d[13:0] ^ 14'h2a5;
    ca = d[5:0] ^ 6'h15;
    return {sof, eof, rw, ra, ca, d};
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req_v);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a frame is handed to a controller.
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (bus.axi_wframe_valid && bus.axi_wframe_ready) begin
      vectors++;
      if (exp_w.size() == 0) begin
        miscompares++;
        $display("FAIL wframe_unexpected: got %h expected none", bus.axi_wframe_data);
      end else begin
        e = exp_w.pop_front();
        if (bus.axi_wframe_data !== e) begin
          miscompares++;
          $display("FAIL wframe_data: got %h expected %h", bus.axi_wframe_data, e);
        end
      end
    end
    if (bus.axi_rframe_valid && bus.axi_rframe_ready) begin
      vectors++;
      if (exp_r.size() == 0) begin
        miscompares++;
        $display("FAIL rframe_unexpected: got %h expected none", bus.axi_rframe_data);
      end else begin
        e = exp_r.pop_front();
        if (bus.axi_rframe_data !== e) begin
          miscompares++;
          $display("FAIL rframe_data: got %h expected %h", bus.axi_rframe_data, e);
        end
      end
    end
    if (bus.frame_err) begin
      vectors++;
      if (err_exp == 0) begin
        miscompares++;
        $display("FAIL frame_err_unexpected: got 1 expected 0");
      end else begin
        err_exp--;
      end
    end
    if (bus.ref_miss) miss_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present_wr(input logic [FW-1:0] f);
    bus.wr_frame_data  = f;
    bus.wr_frame_valid = 1'b1;
    exp_w.push_back(f);
  endtask

  task automatic present_rd(input logic [FW-1:0] f);
    bus.rd_frame_data  = f;
    bus.rd_frame_valid = 1'b1;
    exp_r.push_back(f);
  endtask

  // Returns the number of idle negedges before upstream ready rose (-1 on timeout).
  task automatic wait_wr_hs(output int w);
    w = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wr_frame_ready) begin
        w = i;
        break;
      end
    end
    check("wr_hs_ready", 32'(bus.wr_frame_ready), 32'd1);
    check("wr_hs_sel", 32'(bus.array_sel), 32'd1);
    check("wr_hs_rd_ready", 32'(bus.rd_frame_ready), 32'd0);
    tick();
    bus.wr_frame_valid = 1'b0;
  endtask

  task automatic wait_rd_hs(output int w);
    w = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rd_frame_ready) begin
        w = i;
        break;
      end
    end
    check("rd_hs_ready", 32'(bus.rd_frame_ready), 32'd1);
    check("rd_hs_sel", 32'(bus.array_sel), 32'd2);
    check("rd_hs_wr_ready", 32'(bus.wr_frame_ready), 32'd0);
    tick();
    bus.rd_frame_valid = 1'b0;
  endtask

  task automatic pulse_wfin;
    bus.write_finish = 1'b1;
    tick();
    bus.write_finish = 1'b0;
  endtask

  task automatic pulse_rfin;
    bus.read_finish = 1'b1;
    tick();
    bus.read_finish = 1'b0;
  endtask

  task automatic serve(input bit is_wr, input string nm);
    int w;
    if (is_wr) begin
      wait_wr_hs(w);
      check({nm, "_wr_latency"}, 32'(w), 32'd1);
      pulse_wfin();
    end else begin
      wait_rd_hs(w);
      check({nm, "_rd_latency"}, 32'(w), 32'd1);
      pulse_rfin();
    end
  endtask

  task automatic rr_round(input bit wr_first, input logic [63:0] tag, input string nm);
    present_wr(mk(1'b1, 1'b1, 1'b0, tag));
    present_rd(mk(1'b1, 1'b1, 1'b1, ~tag));
    serve(wr_first, nm);
    serve(!wr_first, nm);
  endtask

  task automatic wait_sel(input logic [1:0] s, input int max_n);
    for (int i = 0; i < max_n; i++) begin
      @(negedge clk);
      if (bus.array_sel == s) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, n, c1, c2, m0;
    bus.mc_trefi_cfg     = '0;
    bus.wr_frame_data    = '0;
    bus.wr_frame_valid   = 1'b0;
    bus.rd_frame_data    = '0;
    bus.rd_frame_valid   = 1'b0;
    bus.axi_wframe_ready = 1'b1;
    bus.axi_rframe_ready = 1'b1;
    bus.write_finish     = 1'b0;
    bus.read_finish      = 1'b0;
    bus.refresh_finish   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_array_sel", 32'(bus.array_sel), 32'd0);
    check("rst_refresh_req", 32'(bus.refresh_req), 32'd0);
    check("rst_readys", 32'({bus.wr_frame_ready, bus.rd_frame_ready}), 32'd0);
    check("rst_valids", 32'({bus.axi_wframe_valid, bus.axi_rframe_valid}), 32'd0);
    check("rst_pulses", 32'({bus.frame_err, bus.ref_miss}), 32'd0);
    tick();

    // Simultaneous requests out of reset: write wins, then read.
    rr_round(1'b1, 64'h1111_0000_0000_0001, "rr1");

    // Four-frame write burst, read idle.
    present_wr(mk(1'b1, 1'b0, 1'b0, 64'hA000_0000_0000_0000));
    wait_wr_hs(w);
    check("wr4_grant_latency", 32'(w), 32'd1);
    for (int i = 1; i < 4; i++) begin
      present_wr(mk(1'b0, (i == 3), 1'b0, 64'hA000_0000_0000_0000 + 64'(i) * 64'h0101));
      wait_wr_hs(w);
      check("wr4_no_bubble", 32'(w), 32'd0);
    end
    bus.read_finish    = 1'b1;
    bus.refresh_finish = 1'b1;
    tick();
    bus.read_finish    = 1'b0;
    bus.refresh_finish = 1'b0;
    @(negedge clk);
    check("wr_wait_ignores_finish", 32'(bus.array_sel), 32'd1);
    check("wr_wait_ready", 32'(bus.wr_frame_ready), 32'd0);
    tick();
    pulse_wfin();
    @(negedge clk);
    check("wr4_back_idle", 32'(bus.array_sel), 32'd0);
    tick();

    // Last grant was write, so read wins the next tie.
    rr_round(1'b0, 64'h2222_0000_0000_0002, "rr2");

    // Non-sof read frame in IDLE is swallowed with a frame_err pulse.
    bus.rd_frame_data  = mk(1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0003);
    bus.rd_frame_valid = 1'b1;
    @(negedge clk);
    check("drop_ready", 32'(bus.rd_frame_ready), 32'd1);
    check("drop_no_fwd", 32'(bus.axi_rframe_valid), 32'd0);
    err_exp++;
    tick();
    bus.rd_frame_valid = 1'b0;
    @(negedge clk);
    check("drop_frame_err", 32'(bus.frame_err), 32'd1);
    tick();
    @(negedge clk);
    check("drop_err_one_cycle", 32'(bus.frame_err), 32'd0);
    check("drop_stay_idle", 32'(bus.array_sel), 32'd0);
    tick();

    // Refresh cadence with cfg=100.
    m0 = miss_seen;
    bus.mc_trefi_cfg = 16'd100;
    n = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.refresh_req) begin
        n = i;
        break;
      end
    end
    c1 = int'(cyc);
    check("ref1_first_latency", 32'(n), 32'd2);
    check("ref1_sel", 32'(bus.array_sel), 32'd3);
    repeat (3) tick();
    @(negedge clk);
    check("ref1_held", 32'(bus.refresh_req), 32'd1);
    tick();
    bus.refresh_finish = 1'b1;
    tick();
    bus.refresh_finish = 1'b0;
    @(negedge clk);
    check("ref1_drop", 32'(bus.refresh_req), 32'd0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.refresh_req) break;
    end
    c2 = int'(cyc);
    check("ref1_second_req", 32'(bus.refresh_req), 32'd1);
    check("ref1_interval", 32'(c2 - c1), 32'd100);
    tick();
    bus.mc_trefi_cfg   = '0;
    bus.refresh_finish = 1'b1;
    tick();
    bus.refresh_finish = 1'b0;
    check("ref1_no_miss", 32'(miss_seen - m0), 32'd0);

    // cfg=20 with a long write burst: refresh waits, two misses, then beats the queued read.
    m0 = miss_seen;
    bus.mc_trefi_cfg = 16'd20;
    present_wr(mk(1'b1, 1'b0, 1'b0, 64'h3333_0000_0000_0004));
    wait_wr_hs(w);
    check("ref2_burst_granted", 32'(w), 32'd1);
    present_rd(mk(1'b1, 1'b1, 1'b1, 64'h4444_0000_0000_0005));
    present_wr(mk(1'b0, 1'b1, 1'b0, 64'h3333_0000_0000_0006));
    wait_wr_hs(w);
    repeat (46) @(posedge clk);
    #1;
    pulse_wfin();
    @(negedge clk);
    check("ref2_idle_sel", 32'(bus.array_sel), 32'd0);
    check("ref2_idle_rd_ready", 32'(bus.rd_frame_ready), 32'd0);
    tick();
    @(negedge clk);
    check("ref2_ref_req", 32'(bus.refresh_req), 32'd1);
    check("ref2_ref_sel", 32'(bus.array_sel), 32'd3);
    check("ref2_ref_rd_ready", 32'(bus.rd_frame_ready), 32'd0);
    check("ref2_miss_count", 32'(miss_seen - m0), 32'd2);
    tick();
    bus.refresh_finish = 1'b1;
    tick();
    bus.refresh_finish = 1'b0;
    wait_rd_hs(w);
    check("ref2_read_after_ref", 32'(w), 32'd1);
    pulse_rfin();
    wait_sel(2'd3, 20);
    check("ref2_next_ref", 32'(bus.array_sel), 32'd3);
    tick();
    bus.refresh_finish = 1'b1;
    bus.mc_trefi_cfg   = '0;
    tick();
    bus.refresh_finish = 1'b0;
    check("ref2_miss_final", 32'(miss_seen - m0), 32'd2);
    tick();

    // Reset in the middle of a five-frame read burst.
    present_rd(mk(1'b1, 1'b0, 1'b1, 64'h5555_0000_0000_0000));
    wait_rd_hs(w);
    present_rd(mk(1'b0, 1'b0, 1'b1, 64'h5555_0000_0000_0001));
    wait_rd_hs(w);
    check("rst_burst_2nd_frame", 32'(w), 32'd0);
    bus.axi_rframe_ready = 1'b0;
    bus.rd_frame_data    = mk(1'b0, 1'b0, 1'b1, 64'h5555_0000_0000_0002);
    bus.rd_frame_valid   = 1'b1;
    tick();
    rst = 1'b1;
    bus.rd_frame_valid   = 1'b0;
    bus.axi_rframe_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sel", 32'(bus.array_sel), 32'd0);
    check("midrst_readys", 32'({bus.wr_frame_ready, bus.rd_frame_ready}), 32'd0);
    check("midrst_valids", 32'({bus.axi_wframe_valid, bus.axi_rframe_valid}), 32'd0);
    check("midrst_refresh", 32'(bus.refresh_req), 32'd0);
    tick();
    present_wr(mk(1'b1, 1'b0, 1'b0, 64'h6666_0000_0000_0000));
    wait_wr_hs(w);
    check("post_rst_grant", 32'(w), 32'd1);
    present_wr(mk(1'b0, 1'b1, 1'b0, 64'h6666_0000_0000_0001));
    wait_wr_hs(w);
    pulse_wfin();
    @(negedge clk);
    check("post_rst_idle", 32'(bus.array_sel), 32'd0);

    check("sb_wr_drained", 32'(exp_w.size()), 32'd0);
    check("sb_rd_drained", 32'(exp_r.size()), 32'd0);
    check("sb_err_drained", 32'(err_exp), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_array_arbiter.md
Name: mc_array_arbiter

Overview:
- Shares the single DRAM-style array between the write controller (array_wr_ctrl), the read controller (array_rd_ctrl) and the refresh engine.
- Sits between the AXI frame builders and the two array controllers.
- Accepts whole bursts (sof..eof frames) from separate write and read frame streams. Grants one burst at a time and holds the grant until the owning controller reports finish.
- Generates periodic refresh requests from a tREFI timer. A pending refresh takes priority at every burst boundary.

Parameters:
DATA_WIDTH, 64, data field width of a frame
RADDR_WIDTH, 14, row address width
CADDR_WIDTH, 6, column address width
FRAME_WIDTH, DATA_WIDTH+RADDR_WIDTH+CADDR_WIDTH+3, frame = {sof, eof, rw_flag, raddr, caddr, data}
REFI_WIDTH, 16, width of the refresh interval counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mc_trefi_cfg  in  REFI_WIDTH  refresh interval in cycles; 0 = refresh disabled
wr_frame_data  in  FRAME_WIDTH  upstream write frame
wr_frame_valid  in  1  upstream write valid
wr_frame_ready  out  1  upstream write ready
rd_frame_data  in  FRAME_WIDTH  upstream read frame
rd_frame_valid  in  1  upstream read valid
rd_frame_ready  out  1  upstream read ready
axi_wframe_data  out  FRAME_WIDTH  to write ctrl
axi_wframe_valid  out  1  to write ctrl
axi_wframe_ready  in  1  from write ctrl
write_finish  in  1  write ctrl burst done pulse
axi_rframe_data  out  FRAME_WIDTH  to read ctrl
axi_rframe_valid  out  1  to read ctrl
axi_rframe_ready  in  1  from read ctrl
read_finish  in  1  read ctrl burst done pulse
refresh_req  out  1  level request to refresh engine
refresh_finish  in  1  refresh done pulse
array_sel  out  2  array mux select: 0 none, 1 write, 2 read, 3 refresh
frame_err  out  1  one-cycle pulse: non-sof frame dropped in IDLE
ref_miss  out  1  one-cycle pulse: timer expired while refresh already pending

Behaviour:
Reset: state IDLE. All outputs 0, refresh counter = 0, ref_pending = 0, last_grant = read (write wins first tie).

States and transitions:
- IDLE:
  - ref_pending -> REF.
  - Otherwise, a valid frame with sof=1 on the write and/or read stream -> WR_XFER or RD_XFER.
  - If both are requesting, round-robin against last_grant.
  - Decision is registered; the frame is forwarded starting the cycle after the IDLE decision (1-cycle grant latency).
- IDLE drop rule: a valid frame with sof=0 is accepted (ready=1) and discarded, and frame_err pulses. This applies per stream, only when that stream is not being granted this cycle.
- WR_XFER:
  - axi_wframe_data/valid = wr_frame_data/valid; wr_frame_ready = axi_wframe_ready.
  - Pure combinational pass-through, no bubble.
  - Handshake with eof=1 -> WR_WAIT.
  - A sof=1 frame with eof=1 is a single-frame burst and is legal.
- WR_WAIT: both upstream ready = 0. write_finish -> IDLE, last_grant = write.
- RD_XFER / RD_WAIT: mirror of the write pair, using the read ports, read_finish and last_grant = read.
- REF: refresh_req = 1, ref_pending cleared on entry. refresh_finish -> IDLE, refresh_req = 0 in the same edge.

array_sel and ready rules:
- array_sel is registered from state: 1 in WR_XFER/WR_WAIT, 2 in RD_XFER/RD_WAIT, 3 in REF, 0 in IDLE.
- The downstream valid of a non-owner is forced to 0.
- Upstream ready is 0 outside the IDLE drop rule and the owning XFER state.

Refresh timer:
- If mc_trefi_cfg = 0: counter held at 0, no expiries.
- Otherwise: count down from mc_trefi_cfg-1. At 0, reload and set ref_pending.
- Expiry while ref_pending=1 pulses ref_miss; ref_pending stays 1 (no counting of misses).
- Timer runs in every state, including REF.
- A cfg change takes effect at the next reload.

Ignored and simultaneous events:
- write_finish outside WR_WAIT, read_finish outside RD_WAIT, and refresh_finish outside REF are ignored.
- Timer expiry in the same cycle IDLE evaluates is seen next cycle. The burst granted that cycle proceeds; the refresh waits for the next IDLE.
- Refresh never preempts a burst mid-transfer.

Reset mid-burst: immediate return to IDLE; all outputs and ready signals drop in the following cycle.

Decomposition:
- Shared package mc_pkg:
  - frame field offsets (SOF_BIT, EOF_BIT, RW_BIT, RADDR_LSB, CADDR_LSB)
  - state encoding localparams
  - array_sel codes (SEL_NONE/WR/RD/REF)
- One sub-module, mc_refi_timer: counter, ref_pending, ref_miss. Input clear_pending from the arbiter.
- The FSM and muxing stay in the top module.

Test Plan:
- Write burst of 4 frames (sof on 1st, eof on 4th), read idle -> array_sel=1 one cycle after sof. 4 handshakes forwarded unchanged. rd_frame_ready=0 throughout. After write_finish, state returns to IDLE and array_sel=0.
- Write and read sof both valid in the same cycle from reset -> write granted first. After write_finish, read granted next (round-robin). Repeat: write and read alternate.
- mc_trefi_cfg=100, no traffic -> refresh_req rises every ~100 cycles. Held until refresh_finish; drops at the edge where refresh_finish is sampled.
- mc_trefi_cfg=20 with a write burst lasting 60 cycles before write_finish -> refresh waits for burst end. ref_miss pulses twice. REF is entered immediately after write_finish, before a pending read.
- Read frame with sof=0 presented in IDLE -> accepted, frame_err=1 for 1 cycle, no downstream valid.
- rst asserted in RD_XFER after 2 of 5 frames -> next cycle array_sel=0, all valids/readys 0, refresh counter restarted. A new write burst then starts cleanly.
